// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM state type and rotate helper for cpu_alu_seq
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_MUL  = 5'd3;
    localparam logic [4:0] OP_DIV  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_NEG  = 5'd7;
    localparam logic [4:0] OP_NOT  = 5'd8;
    localparam logic [4:0] OP_SHRA = 5'd9;
    localparam logic [4:0] OP_SHL  = 5'd10;
    localparam logic [4:0] OP_SHR  = 5'd11;
    localparam logic [4:0] OP_ROL  = 5'd14;
    localparam logic [4:0] OP_ROR  = 5'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } alu_state_e;

    localparam int unsigned ROT_MAXW = 128;
    localparam int unsigned ROT_IW   = 7;

    // Rotate the low w bits of x left by amt (mod w); bits at and above w come back zero.
    function automatic logic [ROT_MAXW-1:0] rotl(input logic [ROT_MAXW-1:0] x,
                                                 input int unsigned w,
                                                 input int unsigned amt);
        logic [ROT_MAXW-1:0] r;
        logic [ROT_IW-1:0]   dst;
        r   = '0;
        dst = '0;
        for (int unsigned i = 0; i < ROT_MAXW; i++) begin
            if (i < w) begin
                dst    = ROT_IW'((i + amt) % w);
                r[dst] = x[ROT_IW'(i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cpu_alu_seq_if.sv
// rtl/cpu_alu_seq_if.sv - start/busy/done request and result bundle between control unit and ALU
interface cpu_alu_seq_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic [4:0]         opcode;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               busy;
    logic               done;
    logic               div_by_zero;
    logic [2*WIDTH-1:0] C_register;

    modport master (
        output start, opcode, A, B,
        input  busy, done, div_by_zero, C_register
    );

    modport slave (
        input  start, opcode, A, B,
        output busy, done, div_by_zero, C_register
    );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - signed restoring divider, one quotient bit per cycle on magnitudes
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             go,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz,
    output logic             fin
);
    localparam int CW = $clog2(WIDTH);

    logic             run_q;
    logic             zero_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] first_step;
    logic [2*WIDTH-1:0] next_step;

    // Shift the next dividend bit into the partial remainder and subtract if it fits.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                    input logic [WIDTH-1:0] quo,
                                                    input logic [WIDTH-1:0] dvs);
        logic [WIDTH:0]     r;
        logic [WIDTH:0]     t;
        logic [2*WIDTH-1:0] res;
        r = {rem, quo[WIDTH-1]};
        t = r - {1'b0, dvs};
        if (!t[WIDTH]) begin
            res = {t[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
        end else begin
            res = {r[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
        end
        return res;
    endfunction

    assign mag_a = dividend[WIDTH-1] ? -dividend : dividend;
    assign mag_b = divisor[WIDTH-1]  ? -divisor  : divisor;

    // The first bit is resolved on the go edge so WIDTH bits are ready one cycle earlier.
    assign first_step = div_step({WIDTH{1'b0}}, mag_a, mag_b);
    assign next_step  = div_step(rem_q, quo_q, dvs_q);

    always_ff @(posedge clk) begin
        if (clear) begin
            run_q     <= 1'b0;
            zero_q    <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            a_q       <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
        end else if (go) begin
            run_q          <= (divisor != '0);
            zero_q         <= (divisor == '0);
            neg_quo_q      <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_q      <= dividend[WIDTH-1];
            a_q            <= dividend;
            dvs_q          <= mag_b;
            {rem_q, quo_q} <= first_step;
            cnt_q          <= CW'(WIDTH - 1);
        end else if (run_q) begin
            {rem_q, quo_q} <= next_step;
            cnt_q          <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_q <= 1'b0;
            end
        end
    end

    assign fin       = run_q && (cnt_q == CW'(1));
    assign dz        = zero_q;
    assign quotient  = zero_q ? {WIDTH{1'b1}} : (neg_quo_q ? -quo_q : quo_q);
    assign remainder = zero_q ? a_q           : (neg_rem_q ? -rem_q : rem_q);

endmodule

// File: rtl/cpu_alu_seq.sv
// rtl/cpu_alu_seq.sv - multi-cycle ALU: single-cycle logic/shift ops, Booth multiply, restoring divide
module cpu_alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         clear,
    cpu_alu_seq_if.slave bus
);
    localparam int PW = 2 * WIDTH + 2;

    alu_state_e         state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]      p_q, p_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               is_div_q, is_div_d;
    logic [2*WIDTH-1:0] c_q, c_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic [SHW-1:0]      amt;
    logic [ROT_MAXW-1:0] rot_l;
    logic [ROT_MAXW-1:0] rot_r;
    logic [WIDTH-1:0]    sc_result;

    logic             div_go;
    logic             div_fin;
    logic             div_dz;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;

    // Booth accumulator layout: {hi (WIDTH+1, sign-extended), multiplier (WIDTH), q_-1}.
    function automatic logic [PW-1:0] booth_step(input logic [PW-1:0] p,
                                                 input logic [WIDTH-1:0] m);
        logic [WIDTH:0] hi;
        logic [WIDTH:0] mx;
        mx = {m[WIDTH-1], m};
        hi = p[PW-1:WIDTH+1];
        case (p[1:0])
            2'b01:   hi = hi + mx;
            2'b10:   hi = hi - mx;
            default: hi = hi;
        endcase
        return {hi[WIDTH], hi, p[WIDTH:1]};
    endfunction

    assign amt = bus.B[SHW-1:0];

    always_comb begin
        sc_result = '0;
        rot_l     = rotl(ROT_MAXW'(bus.A), WIDTH, 32'(amt));
        rot_r     = rotl(ROT_MAXW'(bus.A), WIDTH, WIDTH - 32'(amt));
        case (bus.opcode)
            OP_ADD:  sc_result = bus.A + bus.B;
            OP_SUB:  sc_result = bus.A - bus.B;
            OP_AND:  sc_result = bus.A & bus.B;
            OP_OR:   sc_result = bus.A | bus.B;
            OP_NEG:  sc_result = -bus.B;
            OP_NOT:  sc_result = ~bus.B;
            OP_SHRA: sc_result = WIDTH'($signed(bus.A) >>> amt);
            OP_SHL:  sc_result = bus.A << amt;
            OP_SHR:  sc_result = bus.A >> amt;
            OP_ROL:  sc_result = rot_l[WIDTH-1:0];
            OP_ROR:  sc_result = rot_r[WIDTH-1:0];
            default: sc_result = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        m_d      = m_q;
        is_div_d = is_div_q;
        c_d      = c_q;
        done_d   = 1'b0;
        dz_d     = dz_q;
        div_go   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.opcode)
                        OP_MUL: begin
                            state_d  = S_MUL;
                            cnt_d    = SHW'(WIDTH - 1);
                            m_d      = bus.A;
                            p_d      = booth_step({{(WIDTH+1){1'b0}}, bus.B, 1'b0}, bus.A);
                            is_div_d = 1'b0;
                        end
                        OP_DIV: begin
                            div_go   = 1'b1;
                            is_div_d = 1'b1;
                            state_d  = (bus.B == '0) ? S_FIN : S_DIV;
                        end
                        default: begin
                            c_d    = {{WIDTH{1'b0}}, sc_result};
                            done_d = 1'b1;
                        end
                    endcase
                end
            end
            S_MUL: begin
                p_d   = booth_step(p_q, m_q);
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = S_FIN;
                end
            end
            S_DIV: begin
                if (div_fin) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                c_d     = is_div_q ? {div_rem, div_quo} : p_q[2*WIDTH:1];
                done_d  = 1'b1;
                if (is_div_q) begin
                    dz_d = div_dz;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            m_q      <= '0;
            is_div_q <= 1'b0;
            c_q      <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            m_q      <= m_d;
            is_div_q <= is_div_d;
            c_q      <= c_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    seq_divider #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk       (clk),
        .clear     (clear),
        .go        (div_go),
        .dividend  (bus.A),
        .divisor   (bus.B),
        .quotient  (div_quo),
        .remainder (div_rem),
        .dz        (div_dz),
        .fin       (div_fin)
    );

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dz_q;
    assign bus.C_register  = c_q;

endmodule

// File: doc/cpu_alu_seq.md
Name: cpu_alu_seq

Overview:
- Parametrised, multi-cycle successor to the datapath ALU. It is fed from the bus (A) and the Y register (B) and writes a 2*WIDTH result to the C register (HI = upper half, LO = lower half).
- Logic and shift ops complete in one cycle.
- Signed MUL and signed DIV are iterative: a full 2*WIDTH product; quotient in LO and remainder in HI.
- A start/busy/done handshake lets the control unit stall during long ops.

Parameters:
- WIDTH, 32: operand width; must be a power of 2, at least 8.
- SHW, $clog2(WIDTH): number of shift/rotate amount bits taken from B.

Ports:
- clk  in  1  rising-edge clock
- clear  in  1  synchronous active-high reset
- start  in  1  one-cycle op request; A, B and opcode are sampled on this edge
- opcode  in  5  operation select
- A  in  WIDTH  operand A (bus)
- B  in  WIDTH  operand B (Y register)
- busy  out  1  iterative op in progress
- done  out  1  one-cycle pulse; C_register is valid from this cycle on
- div_by_zero  out  1  sticky flag for the last DIV; updated with each done
- C_register  out  2*WIDTH  {HI, LO} result; holds its value until the next done

Behaviour:
- Opcodes: ADD=1, SUB=2, MUL=3, DIV=4, AND=5, OR=6, NEG=7 (-B), NOT=8 (~B), SHRA=9, SHL=10, SHR=11, ROL=14, ROR=15. Any other opcode is illegal.
- Single-cycle ops (all except MUL and DIV):
  - Result is in LO; HI=0.
  - ADD and SUB wrap modulo 2^WIDTH.
  - Shift/rotate amount = B[SHW-1:0]; upper bits of B are ignored.
  - SHR is logical (zero fill); SHRA is arithmetic.
- Illegal opcode: C_register=0 and done pulses, same timing as a single-cycle op.
- Reset (clear=1 on any edge, including mid-operation):
  - state -> IDLE; busy=0, done=0, div_by_zero=0, C_register=0.
  - Any in-flight op is dropped with no done.
- State machine states: IDLE, MUL, DIV, FIN.
- IDLE:
  - start with a single-cycle op: C_register and done are registered on the next edge. Latency is 1, busy stays 0, state stays IDLE.
  - start with MUL: go to MUL. start with DIV: go to DIV. Iteration counter loads WIDTH-1.
- MUL:
  - Radix-2 Booth over the sampled operands, one bit per cycle, WIDTH cycles, then go to FIN.
  - Product is signed, full 2*WIDTH; no overflow is possible.
- DIV:
  - Restoring divide on magnitudes, WIDTH cycles, then go to FIN.
  - Sign fix-up is done in FIN: quotient is negated if the operand signs differ; remainder takes the sign of the dividend (truncation toward zero).
  - B=0: skip iterations and go directly to FIN with LO=all-ones, HI=A, div_by_zero=1. Otherwise div_by_zero=0.
  - MIN_INT / -1: LO=MIN_INT (wrap), HI=0.
- FIN: register C_register, pulse done, clear busy, return to IDLE.
- busy timing: busy=1 in every cycle from the edge after start until the FIN edge. Total latency is WIDTH+1 edges after start (DIV by zero: 2 edges).
- start while busy: ignored with no side effects.
- start on the same edge as done: accepted (back-to-back ops).
- start coincident with clear: clear wins.
- Operands are latched on start; changes to A, B or opcode during busy have no effect.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD ... OP_ROR);
  - the state enum (S_IDLE, S_MUL, S_DIV, S_FIN);
  - a WIDTH-generic rotate function.
- One sub-module, seq_divider (WIDTH param; ports clk, clear, go, dividend, divisor, quotient, remainder, dz, fin).
  - It owns the magnitude iteration and sign fix-up.
  - The top-level handles the FSM, Booth multiply and the single-cycle ops.

Test Plan (WIDTH=32):
- ADD A=0x7FFFFFFF, B=1 -> done 1 cycle after start, busy never 1, C=0x00000000_80000000. SUB A=0, B=1 -> C=0x00000000_FFFFFFFF.
- MUL A=0xFFFFFFFD (-3), B=7 -> busy high for 32 cycles, done on edge 33, C=0xFFFFFFFF_FFFFFFEB. MUL 0x80000000*0x80000000 -> C=0x40000000_00000000.
- DIV A=-17, B=5 -> LO=0xFFFFFFFD, HI=0xFFFFFFFE, div_by_zero=0. DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV A=9, B=0 -> done on edge 2, LO=0xFFFFFFFF, HI=9, div_by_zero=1. A following ADD leaves div_by_zero=1 until the next DIV.
- ROR A=1, B=1 -> 0x80000000. SHR A=0x80000000, B=4 -> 0x08000000. SHRA same operands -> 0xF8000000. ROL A=1, B=33 -> 2. opcode 12 -> C=0 with done.
- Start MUL, then pulse start (ADD) at cycle 5 -> ignored. Assert clear at cycle 10 -> busy=0, C=0, no done. Start ADD on the next cycle -> completes normally.
